// File: rtl/itcm_pkg.sv
// ---------------------------------------------------------------------------
// itcm_pkg : shared widths and loader state encoding for the itcm boot loader
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package itcm_pkg;

    localparam int ITCM_ADDR_WIDTH = 14;
    localparam int ITCM_DATA_WIDTH = 32;
    localparam int BPW             = ITCM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_CHECK  = 2'd3
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/itcm_word_packer.sv
// ---------------------------------------------------------------------------
// itcm_word_packer : packs a byte stream LSB-first into DATA_WIDTH-bit words
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module itcm_word_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    input  logic                  i_ready,
    output logic                  o_word_valid,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_fire;
    logic                  w_last;

    assign w_fire = i_valid & i_ready;
    assign w_last = (r_cnt == CNT_W'(BPW - 1));

    // The completing byte is merged combinationally so the word is ready on the handshake edge.
    assign o_word       = {i_byte, r_shift[DATA_WIDTH-1:8]};
    assign o_word_valid = w_fire & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_flush) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_fire) begin
            r_shift <= {i_byte, r_shift[DATA_WIDTH-1:8]};
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/itcm_loader.sv
// ---------------------------------------------------------------------------
// itcm_loader : boot-time itcm initiator - stream load, readback, checksum compare
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module itcm_loader
    import itcm_pkg::*;
#(
    parameter int ADDR_WIDTH = ITCM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ITCM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [ADDR_WIDTH:0] c_full_count = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_t         r_state;
    logic                  r_s_ready;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  r_mem_wr_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_bad;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [DATA_WIDTH-1:0] r_rd_sum;
    logic [ADDR_WIDTH:0]   r_wc;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [ADDR_WIDTH:0]   r_vaddr;
    logic                  r_rd_addr_v;
    logic                  r_rd_data_v;

    logic                  w_start_ok;
    logic                  w_word_valid;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_start_ok = start & (r_state == ST_IDLE);

    itcm_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (w_start_ok),
        .i_byte       (s_data),
        .i_valid      (s_valid),
        .i_ready      (r_s_ready),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_s_ready     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_en   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_bad         <= 1'b0;
            r_checksum    <= '0;
            r_rd_sum      <= '0;
            r_wc          <= '0;
            r_word_idx    <= '0;
            r_vaddr       <= '0;
            r_rd_addr_v   <= 1'b0;
            r_rd_data_v   <= 1'b0;
        end else begin
            r_mem_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_checksum  <= '0;
                        r_rd_sum    <= '0;
                        r_word_idx  <= '0;
                        r_vaddr     <= '0;
                        r_rd_addr_v <= 1'b0;
                        r_rd_data_v <= 1'b0;
                        r_wc        <= word_count;
                        r_busy      <= 1'b1;
                        // Empty or oversized requests finish through CHECK without touching memory.
                        if ((word_count == '0) || (word_count > c_full_count)) begin
                            r_bad   <= (word_count != '0);
                            r_state <= ST_CHECK;
                        end else begin
                            r_bad     <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_valid) begin
                        r_mem_wr_en   <= 1'b1;
                        r_mem_addr    <= r_word_idx[ADDR_WIDTH-1:0];
                        r_mem_wr_data <= w_word;
                        r_checksum    <= r_checksum + w_word;
                        r_word_idx    <= r_word_idx + 1'b1;
                        r_s_ready     <= 1'b0;
                        if ((r_word_idx + 1'b1) == r_wc) begin
                            r_state <= ST_VERIFY;
                        end
                    end else begin
                        r_s_ready <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (r_vaddr < r_wc) begin
                        r_mem_addr  <= r_vaddr[ADDR_WIDTH-1:0];
                        r_vaddr     <= r_vaddr + 1'b1;
                        r_rd_addr_v <= 1'b1;
                    end else begin
                        r_rd_addr_v <= 1'b0;
                    end
                    // Read data trails its address by one cycle.
                    r_rd_data_v <= r_rd_addr_v;
                    if (r_rd_data_v) begin
                        r_rd_sum <= r_rd_sum + mem_rd_data;
                    end
                    if (r_rd_data_v && !r_rd_addr_v && (r_vaddr == r_wc)) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_error <= r_bad | (r_rd_sum != r_checksum);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_en   = r_mem_wr_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign checksum    = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_itcm_loader.sv
// ---------------------------------------------------------------------------
// tb_itcm_loader : scoreboard bench for itcm_loader with a behavioural itcm RAM
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_itcm_loader;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    itcm_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word_count  (word_count),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read; optional bit-0 corruption of word 1 on readback.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          flip_w1 = 1'b0;
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr] ^ {{(DW-1){1'b0}}, (flip_w1 && mem_addr == AW'(1))};
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        logic          err;
        logic [DW-1:0] sum;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write and every completion is checked against the queued expectation.
    initial begin
        logic prev_done;
        wr_t  w;
        dn_t  d;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", {mem_addr, mem_wr_data}, '0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", 64'(mem_addr), 64'(w.addr));
                        chk("wr_data", 64'(mem_wr_data), 64'(w.data));
                    end
                end
                if (done && !prev_done) begin
                    if (exp_dn.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        d = exp_dn.pop_front();
                        chk("done_error", 64'(error), 64'(d.err));
                        chk("done_checksum", 64'(checksum), 64'(d.sum));
                        chk("done_busy", 64'(busy), 64'(0));
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic start_op(input logic [AW:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'(1));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_stream(input int nbytes, input logic [7:0] base, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(base + 8'(i), gaps && ($urandom_range(0, 1) == 1));
        end
    endtask

    // Expected words for a stream of incrementing bytes starting at base.
    task automatic expect_load(input int nwords, input logic [7:0] base, input logic err);
        logic [DW-1:0] sum;
        logic [7:0]    b;
        wr_t           w;
        dn_t           d;
        sum = '0;
        for (int i = 0; i < nwords; i++) begin
            b      = base + 8'(4 * i);
            w.addr = AW'(i);
            w.data = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            sum    = sum + w.data;
            exp_wr.push_back(w);
        end
        d.err = err;
        d.sum = sum;
        exp_dn.push_back(d);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 64'(done), 64'(1));
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_s_ready"}, 64'(s_ready), 64'(0));
        chk({name, "_wr_en"}, 64'(mem_wr_en), 64'(0));
        chk({name, "_addr"}, 64'(mem_addr), 64'(0));
        chk({name, "_wr_data"}, 64'(mem_wr_data), 64'(0));
        chk({name, "_busy"}, 64'(busy), 64'(0));
        chk({name, "_done"}, 64'(done), 64'(0));
        chk({name, "_error"}, 64'(error), 64'(0));
        chk({name, "_checksum"}, 64'(checksum), 64'(0));
    endtask

    initial begin
        wr_t w;
        dn_t d;
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: two words, hand-packed values
        w.addr = 14'd0; w.data = 32'h0403_0201; exp_wr.push_back(w);
        w.addr = 14'd1; w.data = 32'h0807_0605; exp_wr.push_back(w);
        d.err = 1'b0; d.sum = 32'h0C0A_0806; exp_dn.push_back(d);
        start_op(15'd2);
        send_stream(8, 8'h01, 1'b0);
        wait_done("t1");

        // T2: zero words completes within two cycles
        d.err = 1'b0; d.sum = 32'h0; exp_dn.push_back(d);
        start_op(15'd0);
        @(negedge clk);
        chk("t2_done_2cyc", 64'(done), 64'(1));
        @(negedge clk);

        // T3: word_count one beyond full depth
        d.err = 1'b1; d.sum = 32'h0; exp_dn.push_back(d);
        start_op(15'h4001);
        repeat (3) @(negedge clk);
        chk("t3_done", 64'(done), 64'(1));
        chk("t3_s_ready", 64'(s_ready), 64'(0));

        // T4: corrupted readback of word 1
        flip_w1 = 1'b1;
        w.addr = 14'd0; w.data = 32'h0403_0201; exp_wr.push_back(w);
        w.addr = 14'd1; w.data = 32'h0807_0605; exp_wr.push_back(w);
        d.err = 1'b1; d.sum = 32'h0C0A_0806; exp_dn.push_back(d);
        start_op(15'd2);
        send_stream(8, 8'h01, 1'b0);
        wait_done("t4");
        flip_w1 = 1'b0;

        // T5: sixteen words without and with stream gaps
        expect_load(16, 8'h10, 1'b0);
        start_op(15'd16);
        send_stream(64, 8'h10, 1'b0);
        wait_done("t5_nogap");
        expect_load(16, 8'h10, 1'b0);
        start_op(15'd16);
        send_stream(64, 8'h10, 1'b1);
        wait_done("t5_gap");

        // T6: reset after six bytes, then a clean one-word load
        w.addr = 14'd0; w.data = 32'h2322_2120; exp_wr.push_back(w);
        start_op(15'd4);
        send_stream(6, 8'h20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        rst = 1'b0;
        @(negedge clk);
        expect_load(1, 8'h40, 1'b0);
        start_op(15'd1);
        send_stream(4, 8'h40, 1'b0);
        wait_done("t6_reload");
        chk("t6_ram0", 64'(ram[0]), 64'h4342_4140);

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        chk("done_queue_empty", 64'(exp_dn.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
